rv0_fpu_seq: RTL and testbench
==============================

// Module: rv0_fpu_seq
// PURPOSE
//  Issue/sequencing controller for the combinational FP ALU (rv0_alu_f).
//  - Accepts one RV32F OP-FP instruction at a time over a valid/ready issue port.
//  - Holds the ALU operands stable for an op-dependent number of cycles.
//  - Captures the ALU result and returns it over a valid/ready writeback port.
//  - Owns the sticky fflags CSR field.
// PARAMETERS
//  FLEN        32  FP register width
//  LAT_ADD     2   EXEC cycles for FADD.S/FSUB.S (>=1)
//  LAT_MUL     3   EXEC cycles for FMUL.S (>=1)
//  LAT_MINMAX  1   EXEC cycles for FMIN.S/FMAX.S (>=1)
// PORTS
//  clk_i            in   1     clock
//  rst_i            in   1     synchronous active-high reset
//  issue_valid_i    in   1     issue request
//  issue_ready_o    out  1     controller can accept
//  issue_insn_i     in   32    instruction word
//  issue_rdata1_i   in   FLEN  rs1 value
//  issue_rdata2_i   in   FLEN  rs2 value
//  flush_i          in   1     kill in-flight op
//  illegal_o        out  1     1-cycle pulse: accepted insn is not a supported op
//  busy_o           out  1     state != IDLE
//  alu_f_insn_o     out  32    to ALU alu_f_insn_i
//  alu_f_rdata1_o   out  FLEN  to ALU alu_f_rdata1_i
//  alu_f_rdata2_o   out  FLEN  to ALU alu_f_rdata2_i
//  alu_f_wdata_i    in   FLEN  ALU result
//  alu_f_fflags_i   in   5     ALU flags {NV,DZ,OF,UF,NX}
//  wb_valid_o       out  1     result available
//  wb_ready_i       in   1     consumer accepts result
//  wb_rd_o          out  5     destination reg (insn[11:7])
//  wb_data_o        out  FLEN  result
//  fflags_o         out  5     sticky accrued flags
//  fflags_we_i      in   1     CSR write strobe
//  fflags_wdata_i   in   5     CSR write data
// BEHAVIOUR
//  Reset (sync, rst_i=1): state=IDLE.
//   - All registered outputs and latches are 0; fflags_o=0.
//   - issue_ready_o=0 while rst_i is high.
//  Decode (opcode must be 1010011):
//   - funct7 0000000 = add, 0000100 = sub, 0001000 = mul.
//   - funct7 0010100 with funct3 000 = min, 001 = max.
//   - Anything else is illegal.
//  FSM states IDLE / EXEC / WB.
//   - issue_ready_o = (state==IDLE) & ~flush_i & ~rst_i.
//   - IDLE, on issue_valid_i & issue_ready_o:
//     - Latch insn, rdata1, rdata2.
//     - Legal op: cnt <= LAT-1, go to EXEC.
//     - Illegal op: illegal_o=1 the next cycle, stay in IDLE, no writeback.
//   - EXEC:
//     - alu_f_* outputs driven from the latches; they always hold the last latched value.
//     - cnt decrements each cycle.
//     - At cnt==0: capture alu_f_wdata_i and alu_f_fflags_i, go to WB.
//   - WB:
//     - wb_valid_o=1; wb_rd_o/wb_data_o held stable until the handshake.
//     - On wb_valid_o & wb_ready_i: OR the captured flags into fflags, go to IDLE.
//  Timing:
//   - Accept at edge N gives wb_valid_o from cycle N+LAT+1.
//   - With wb_ready_i=1, the next issue is accepted at edge N+LAT+2.
//   - There is no accept in the same cycle as the WB handshake.
//  Flush:
//   - flush_i in EXEC or WB: go to IDLE next cycle, no writeback, no flag accrual.
//   - flush_i in IDLE blocks acceptance.
//  fflags update priority:
//   - CSR write alone: fflags <= fflags_wdata_i.
//   - CSR write in the same cycle as accrual: fflags <= fflags_wdata_i | captured_flags.
//   - Otherwise fflags only ever ORs; it never clears on its own.
//  Reset mid-operation:
//   - Any state goes to IDLE; wb_valid_o=0 the next cycle.
//   - The pending result is discarded; fflags_o=0.
// TESTING
//  1) FADD.S rd=3, 3F800000+3F800000, wb_ready=1:
//     -> wb_valid at accept+3, wb_data=40000000, wb_rd=3, fflags_o=00000.
//  2) FMUL.S 40400000*40A00000 with wb_ready low for 4 cycles:
//     -> wb_data=41700000 held stable, issue_ready=0 until handshake.
//  3) FADD.S sNaN 7F800001 + 3F800000:
//     -> fflags_o=10000; a following clean FMIN keeps 10000.
//     -> CSR write 00000 clears it.
//  4) Flush at EXEC cycle 2 of FMUL.S:
//     -> no wb_valid, fflags unchanged, issue_ready=1 next cycle.
//  5) funct7=1111111:
//     -> illegal_o single pulse, no wb_valid, busy_o stays 0.
//  6) CSR write 00001 in the WB handshake cycle with captured NV:
//     -> fflags_o=10001.
//     -> Separately: rst_i during WB gives wb_valid=0 next cycle.

Source files
------------

// File: rtl/rv0_fpu_seq_if.sv
// Issue, ALU, writeback and fflags CSR signals of the FP sequencer.
// Signal names match the sequencer's port list; slave is the sequencer side.
interface rv0_fpu_seq_if #(
    parameter int FLEN = 32
);
    logic            issue_valid_i;
    logic            issue_ready_o;
    logic [31:0]     issue_insn_i;
    logic [FLEN-1:0] issue_rdata1_i;
    logic [FLEN-1:0] issue_rdata2_i;
    logic            flush_i;
    logic            illegal_o;
    logic            busy_o;
    logic [31:0]     alu_f_insn_o;
    logic [FLEN-1:0] alu_f_rdata1_o;
    logic [FLEN-1:0] alu_f_rdata2_o;
    logic [FLEN-1:0] alu_f_wdata_i;
    logic [4:0]      alu_f_fflags_i;
    logic            wb_valid_o;
    logic            wb_ready_i;
    logic [4:0]      wb_rd_o;
    logic [FLEN-1:0] wb_data_o;
    logic [4:0]      fflags_o;
    logic            fflags_we_i;
    logic [4:0]      fflags_wdata_i;

    modport slave (
        input  issue_valid_i, issue_insn_i, issue_rdata1_i, issue_rdata2_i, flush_i,
        input  alu_f_wdata_i, alu_f_fflags_i, wb_ready_i, fflags_we_i, fflags_wdata_i,
        output issue_ready_o, illegal_o, busy_o, alu_f_insn_o, alu_f_rdata1_o,
        output alu_f_rdata2_o, wb_valid_o, wb_rd_o, wb_data_o, fflags_o
    );

    modport master (
        output issue_valid_i, issue_insn_i, issue_rdata1_i, issue_rdata2_i, flush_i,
        output alu_f_wdata_i, alu_f_fflags_i, wb_ready_i, fflags_we_i, fflags_wdata_i,
        input  issue_ready_o, illegal_o, busy_o, alu_f_insn_o, alu_f_rdata1_o,
        input  alu_f_rdata2_o, wb_valid_o, wb_rd_o, wb_data_o, fflags_o
    );
endinterface

// File: rtl/rv0_fpu_seq.sv
// Issue/sequencing controller for the combinational FP ALU; owns sticky fflags.
// Latency: result valid LAT cycles after accept (LAT per op class).
// Backpressure: one op in flight; issue blocked until the writeback handshake.
module rv0_fpu_seq #(
    parameter int FLEN       = 32,
    parameter int LAT_ADD    = 2,
    parameter int LAT_MUL    = 3,
    parameter int LAT_MINMAX = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    rv0_fpu_seq_if.slave bus
);
    localparam int CW = 8;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t          state_q, state_d;
    logic [31:0]     insn_q;
    logic [FLEN-1:0] rs1_q, rs2_q, res_q;
    logic [4:0]      flg_q, fflags_q, fflags_d;
    logic [CW-1:0]   cnt_q, lat_sel;
    logic            illegal_q, legal, accept, accrue;

    // Decode of the incoming word; lat_sel of 0 never reaches the counter.
    always_comb begin
        legal   = 1'b0;
        lat_sel = '0;
        if (bus.issue_insn_i[6:0] == 7'b1010011) begin
            unique case (bus.issue_insn_i[31:25])
                7'b0000000, 7'b0000100: begin legal = 1'b1; lat_sel = CW'(LAT_ADD); end
                7'b0001000:             begin legal = 1'b1; lat_sel = CW'(LAT_MUL); end
                7'b0010100: begin
                    if (bus.issue_insn_i[14:12] == 3'b000 || bus.issue_insn_i[14:12] == 3'b001) begin
                        legal   = 1'b1;
                        lat_sel = CW'(LAT_MINMAX);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.issue_ready_o = (state_q == S_IDLE) & ~bus.flush_i & ~rst_i;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        accrue  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                accept = bus.issue_valid_i & bus.issue_ready_o;
                if (accept && legal) state_d = S_EXEC;
            end
            S_EXEC: begin
                if (bus.flush_i)       state_d = S_IDLE;
                else if (cnt_q == '0)  state_d = S_WB;
            end
            S_WB: begin
                if (bus.flush_i) begin
                    state_d = S_IDLE;
                end else if (bus.wb_ready_i) begin
                    accrue  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A CSR write replaces the field, but flags retiring this cycle still stick.
    always_comb begin
        fflags_d = bus.fflags_we_i ? bus.fflags_wdata_i : fflags_q;
        if (accrue) fflags_d = fflags_d | flg_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            insn_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            res_q     <= '0;
            flg_q     <= '0;
            fflags_q  <= '0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            fflags_q  <= fflags_d;
            illegal_q <= accept & ~legal;
            if (accept) begin
                insn_q <= bus.issue_insn_i;
                rs1_q  <= bus.issue_rdata1_i;
                rs2_q  <= bus.issue_rdata2_i;
                if (legal) cnt_q <= lat_sel - CW'(1);
            end
            if (state_q == S_EXEC) begin
                if (cnt_q == '0) begin
                    res_q <= bus.alu_f_wdata_i;
                    flg_q <= bus.alu_f_fflags_i;
                end else begin
                    cnt_q <= cnt_q - CW'(1);
                end
            end
        end
    end

    assign bus.illegal_o      = illegal_q;
    assign bus.busy_o         = (state_q != S_IDLE);
    assign bus.alu_f_insn_o   = insn_q;
    assign bus.alu_f_rdata1_o = rs1_q;
    assign bus.alu_f_rdata2_o = rs2_q;
    assign bus.wb_valid_o     = (state_q == S_WB);
    assign bus.wb_rd_o        = insn_q[11:7];
    assign bus.wb_data_o      = res_q;
    assign bus.fflags_o       = fflags_q;
endmodule

// File: tb/tb_rv0_fpu_seq.sv
// Directed bench for rv0_fpu_seq: a transaction-level model is checked every cycle,
// and hand-computed literals pin the key scenarios.
module tb_rv0_fpu_seq;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    rv0_fpu_seq_if #(.FLEN(32)) bus ();

    rv0_fpu_seq #(.FLEN(32), .LAT_ADD(2), .LAT_MUL(3), .LAT_MINMAX(1)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b1010011};
    endfunction

    function automatic int lat_of(input logic [31:0] insn);
        if (insn[6:0] != 7'b1010011) return 0;
        if (insn[31:25] == 7'h00 || insn[31:25] == 7'h04) return 2;
        if (insn[31:25] == 7'h08) return 3;
        if (insn[31:25] == 7'h14 && (insn[14:12] == 3'd0 || insn[14:12] == 3'd1)) return 1;
        return 0;
    endfunction

    function automatic bit is_snan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && !x[22] && (x[21:0] != 0);
    endfunction

    // Stand-in ALU: {flags, result}; known vectors give true IEEE results.
    function automatic logic [36:0] alu_ref(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        logic [4:0]  f;
        logic [31:0] r;
        f = (is_snan(a) || is_snan(b)) ? 5'b10000 : 5'b00000;
        if (insn[31:25] == 7'h00 && a == 32'h3F800000 && b == 32'h3F800000)      r = 32'h40000000;
        else if (insn[31:25] == 7'h08 && a == 32'h40400000 && b == 32'h40A00000) r = 32'h41700000;
        else if (f != 0)                                                          r = 32'h7FC00000;
        else if (insn[31:25] == 7'h14 && a == 32'h3F800000 && b == 32'h40000000) r = 32'h3F800000;
        else                                                                      r = a ^ b ^ insn;
        return {f, r};
    endfunction

    // The ALU output is only trustworthy in the last EXEC cycle; garbage otherwise.
    int exec_age = 0;
    always @(posedge clk_i) exec_age <= (bus.busy_o && !bus.wb_valid_o) ? exec_age + 1 : 0;
    always_comb begin
        {bus.alu_f_fflags_i, bus.alu_f_wdata_i} = {5'b11111, 32'hDEADBEEF};
        if (exec_age == lat_of(bus.alu_f_insn_o) - 1)
            {bus.alu_f_fflags_i, bus.alu_f_wdata_i} = alu_ref(bus.alu_f_insn_o, bus.alu_f_rdata1_o, bus.alu_f_rdata2_o);
    end

    // Transaction-level model: one op in flight, age counted from accept.
    bit          m_active = 0, m_illegal = 0;
    int          m_age = 0, m_lat = 0;
    logic [4:0]  m_rd = 0, m_flg = 0, m_ff = 0;
    logic [31:0] m_res = 0;

    initial forever begin
        @(posedge clk_i);
        if (rst_i) begin
            m_active = 0; m_illegal = 0; m_ff = 0; m_age = 0;
        end else begin
            bit          acc;
            logic [36:0] o;
            acc  = m_active && (m_age >= m_lat) && bus.wb_ready_i && !bus.flush_i;
            m_ff = (bus.fflags_we_i ? bus.fflags_wdata_i : m_ff) | (acc ? m_flg : 5'b0);
            m_illegal = 0;
            if (m_active) begin
                if (bus.flush_i || acc) m_active = 0;
                else m_age++;
            end else if (bus.issue_valid_i && !bus.flush_i) begin
                if (lat_of(bus.issue_insn_i) == 0) m_illegal = 1;
                else begin
                    o        = alu_ref(bus.issue_insn_i, bus.issue_rdata1_i, bus.issue_rdata2_i);
                    m_active = 1;
                    m_age    = 0;
                    m_lat    = lat_of(bus.issue_insn_i);
                    m_rd     = bus.issue_insn_i[11:7];
                    {m_flg, m_res} = o;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk_i);
        #1;
        chk("issue_ready", 32'(bus.issue_ready_o), 32'(!m_active && !bus.flush_i && !rst_i));
        chk("busy", 32'(bus.busy_o), 32'(m_active));
        chk("wb_valid", 32'(bus.wb_valid_o), 32'(m_active && m_age >= m_lat));
        chk("illegal", 32'(bus.illegal_o), 32'(m_illegal));
        chk("fflags", 32'(bus.fflags_o), 32'(m_ff));
        if (m_active && m_age >= m_lat) begin
            chk("wb_data", bus.wb_data_o, m_res);
            chk("wb_rd", 32'(bus.wb_rd_o), 32'(m_rd));
        end
    end

    // Returns at the negedge following the accept edge.
    task automatic do_issue(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        @(negedge clk_i);
        bus.issue_valid_i = 1; bus.issue_insn_i = insn; bus.issue_rdata1_i = a; bus.issue_rdata2_i = b;
        while (!bus.issue_ready_o && n < 50) begin @(negedge clk_i); n++; end
        if (n >= 50) begin errors++; $display("FAIL issue_timeout: ready stayed 0 for %0d cycles, required 1", n); end
        @(negedge clk_i);
        bus.issue_valid_i = 0;
    endtask

    // Returns at the first negedge with wb_valid high; k = negedges waited.
    task automatic wait_wb(output int k);
        k = 0;
        while (!bus.wb_valid_o && k < 50) begin @(negedge clk_i); k++; end
        if (k >= 50) begin errors++; $display("FAIL wb_timeout: wb_valid stayed 0 for %0d cycles, required 1", k); end
    endtask

    initial begin
        int k;
        bus.issue_valid_i = 0; bus.issue_insn_i = 0; bus.issue_rdata1_i = 0; bus.issue_rdata2_i = 0;
        bus.flush_i = 0; bus.wb_ready_i = 0; bus.fflags_we_i = 0; bus.fflags_wdata_i = 0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", 32'(bus.issue_ready_o), 32'd0);
        chk("rst_fflags", 32'(bus.fflags_o), 32'd0);
        rst_i = 0;

        // 1) FADD 1.0+1.0
        bus.wb_ready_i = 1;
        do_issue(mk(7'h00, 3'd0, 5'd3), 32'h3F800000, 32'h3F800000);
        wait_wb(k);
        chk("t1_latency", 32'(k), 32'd2);
        chk("t1_data", bus.wb_data_o, 32'h40000000);
        chk("t1_rd", 32'(bus.wb_rd_o), 32'd3);
        @(negedge clk_i);
        chk("t1_fflags", 32'(bus.fflags_o), 32'd0);

        // 2) FMUL 3*5 with writeback stalled
        bus.wb_ready_i = 0;
        do_issue(mk(7'h08, 3'd0, 5'd7), 32'h40400000, 32'h40A00000);
        wait_wb(k);
        repeat (4) begin
            chk("t2_data_hold", bus.wb_data_o, 32'h41700000);
            chk("t2_ready_low", 32'(bus.issue_ready_o), 32'd0);
            @(negedge clk_i);
        end
        bus.wb_ready_i = 1;
        @(negedge clk_i);
        chk("t2_done", 32'(bus.wb_valid_o), 32'd0);

        // 3) sNaN add sets NV; clean FMIN keeps it; CSR write clears it
        do_issue(mk(7'h00, 3'd0, 5'd4), 32'h7F800001, 32'h3F800000);
        wait_wb(k);
        chk("t3_qnan", bus.wb_data_o, 32'h7FC00000);
        @(negedge clk_i);
        chk("t3_nv", 32'(bus.fflags_o), 32'h10);
        do_issue(mk(7'h14, 3'd0, 5'd5), 32'h3F800000, 32'h40000000);
        wait_wb(k);
        chk("t3_min_lat", 32'(k), 32'd1);
        chk("t3_min", bus.wb_data_o, 32'h3F800000);
        @(negedge clk_i);
        chk("t3_keep", 32'(bus.fflags_o), 32'h10);
        bus.fflags_we_i = 1; bus.fflags_wdata_i = 5'b00000;
        @(negedge clk_i);
        bus.fflags_we_i = 0;
        #1 chk("t3_clear", 32'(bus.fflags_o), 32'd0);

        // FSUB and FMAX through the model
        do_issue(mk(7'h04, 3'd0, 5'd9), 32'h12345678, 32'h0F0F0F0F);
        wait_wb(k);
        do_issue(mk(7'h14, 3'd1, 5'd10), 32'hA5A5A5A5, 32'h00FF00FF);
        wait_wb(k);
        @(negedge clk_i);

        // 4) Flush during EXEC cycle 2 of FMUL (sNaN operand: flags must not accrue)
        do_issue(mk(7'h08, 3'd0, 5'd6), 32'h7F800001, 32'h40000000);
        @(negedge clk_i);
        bus.flush_i = 1;
        @(negedge clk_i);
        bus.flush_i = 0;
        #1;
        chk("t4_busy", 32'(bus.busy_o), 32'd0);
        chk("t4_ready", 32'(bus.issue_ready_o), 32'd1);
        repeat (4) @(negedge clk_i);
        chk("t4_fflags", 32'(bus.fflags_o), 32'd0);

        // 5) Illegal funct7
        do_issue(mk(7'h7F, 3'd0, 5'd8), 32'h1, 32'h2);
        chk("t5_pulse", 32'(bus.illegal_o), 32'd1);
        chk("t5_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk_i);
        chk("t5_pulse_end", 32'(bus.illegal_o), 32'd0);

        // 6) CSR write coinciding with NV accrual, then reset during WB
        bus.wb_ready_i = 0;
        do_issue(mk(7'h00, 3'd0, 5'd11), 32'h7F800001, 32'h3F800000);
        wait_wb(k);
        bus.fflags_we_i = 1; bus.fflags_wdata_i = 5'b00001; bus.wb_ready_i = 1;
        @(negedge clk_i);
        bus.fflags_we_i = 0; bus.wb_ready_i = 0;
        #1 chk("t6_merge", 32'(bus.fflags_o), 32'h11);
        do_issue(mk(7'h08, 3'd0, 5'd12), 32'h40400000, 32'h40A00000);
        wait_wb(k);
        rst_i = 1;
        @(negedge clk_i);
        chk("t6_rst_wb", 32'(bus.wb_valid_o), 32'd0);
        chk("t6_rst_ff", 32'(bus.fflags_o), 32'd0);
        rst_i = 0;
        repeat (3) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
